counter_seq_ctrl: RTL

- Run-length sequencer for the 4-bit enable/sync-reset counter datapath.
- On a start command it clears the counter, enables it until it reaches a programmed target, supports pause and abort, then pulses done.
- Keeps a shadow count and flags any mismatch against the counter's output, acting as an in-design checker.
- Sits between the control/test logic and one counter instance.

---
 rtl/counter_seq_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/counter_seq_ctrl.sv
// Run-length sequencer for a 4-bit enable/sync-reset counter.
// Clears, enables to a target, supports pause/abort, and shadow-checks the count.
module counter_seq_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] target,
    input  logic             pause,
    input  logic             abort,
    input  logic [CNT_W-1:0] counter_in,
    output logic             cnt_reset,
    output logic             cnt_enable,
    output logic             busy,
    output logic             done,
    output logic             error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_PAUSED = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] shadow_q, shadow_d;
    logic             error_q, error_d;

    logic accept;
    logic at_target;
    logic chk_active;

    assign accept     = (state_q == S_IDLE) && start;
    assign at_target  = (shadow_q == target_q);
    assign chk_active = (state_q == S_RUN) || (state_q == S_PAUSED) ||
                        (state_q == S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_CLEAR;
            S_CLEAR:  state_d = S_RUN;
            S_RUN: begin
                if (at_target) begin
                    state_d = S_DONE;
                end else if (pause) begin
                    state_d = S_PAUSED;
                end
            end
            S_PAUSED: if (!pause) state_d = S_RUN;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        // Abort wins over every transition once a run is in progress
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end
    end

    always_comb begin
        cnt_reset  = 1'b0;
        cnt_enable = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            S_IDLE: ;
            S_CLEAR: begin
                cnt_reset = !abort;
                busy      = 1'b1;
            end
            S_RUN: begin
                cnt_enable = !at_target && !pause && !abort;
                busy       = 1'b1;
            end
            S_PAUSED: busy = 1'b1;
            S_DONE:   done = !abort;
            default: ;
        endcase
    end

    assign error = error_q;

    always_comb begin
        target_d = target_q;
        shadow_d = shadow_q;
        error_d  = error_q;
        if (accept) begin
            target_d = target;
            error_d  = 1'b0;
        end else if (chk_active && (counter_in != shadow_q)) begin
            error_d = 1'b1;
        end
        if (state_q == S_CLEAR) begin
            shadow_d = '0;
        end else if (cnt_enable) begin
            shadow_d = shadow_q + ONE;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            target_q <= '0;
            shadow_q <= '0;
            error_q  <= 1'b0;
        end else begin
            target_q <= target_d;
            shadow_q <= shadow_d;
            error_q  <= error_d;
        end
    end

endmodule
